hps_system_key_debounce: RTL and testbench
==========================================

Name: hps_system_key_debounce

Overview:
- Upstream conditioning stage for the HPS key PIO. It turns the raw, asynchronous, bouncing push-button pins into clean, synchronous, active-high key levels.
- key_clean drives the PIO in_port directly, so software reads stable key state from PIO address 0.
- It also produces one-cycle press/release pulses for fabric logic such as the LED demo and future IRQ capture.

Parameters:
- N_KEYS, 2: number of key channels; must equal the PIO in_port width.
- DEBOUNCE_CYCLES, 500000: consecutive clk cycles a new level must hold before it is accepted (10 ms at 50 MHz). Legal range ≥1.
- ACTIVE_LOW, 1: 1 = raw pin reads 0 when pressed; 0 = raw pin reads 1 when pressed.

Ports:
- clk  input  1  system clock, 50 MHz.
- reset_n  input  1  asynchronous active-low reset.
- key_raw  input  N_KEYS  raw board pins, asynchronous to clk.
- key_clean  output  N_KEYS  debounced level, 1 = pressed; feeds PIO in_port.
- key_press  output  N_KEYS  one-cycle pulse on an accepted released→pressed change.
- key_release  output  N_KEYS  one-cycle pulse on an accepted pressed→released change.

Behaviour:
- Single clock domain: clk. Reset is asynchronous and active-low on reset_n. All flops clear on reset_n=0, independent of clk.
- Reset values:
  - sync stages = idle raw level (all 1 if ACTIVE_LOW, else all 0).
  - key_clean = 0, key_press = 0, key_release = 0.
  - all counters = 0; every channel in STABLE.
- Input conditioning, per channel:
  - 2-flop synchronizer sync1→sync2.
  - lvl = sync2 XOR ACTIVE_LOW, giving an active-high pressed level.
- Per-channel FSM, two states:
  - STABLE: cnt = 0.
    - If lvl ≠ key_clean → PENDING, cnt ← 1.
    - Exception: if DEBOUNCE_CYCLES = 1, accept immediately instead of entering PENDING.
  - PENDING:
    - If lvl = key_clean (bounce back) → STABLE, cnt ← 0, no output change.
    - Else if cnt = DEBOUNCE_CYCLES−1 → accept: key_clean ← lvl, → STABLE, cnt ← 0.
    - Else cnt ← cnt+1.
- Accept edge: in the same cycle key_clean updates, exactly one registered pulse asserts for one cycle.
  - key_press if the new level is 1; key_release if it is 0.
  - Pulses are never asserted together on one channel.
- Latency: a clean raw step sampled at clk edge 0 appears on key_clean and the pulse output at edge DEBOUNCE_CYCLES+2. There is no extra output register.
- Counter width: $clog2(DEBOUNCE_CYCLES+1). The counter never exceeds DEBOUNCE_CYCLES−1 and never wraps.
- Glitches shorter than DEBOUNCE_CYCLES post-sync cycles are fully rejected. Any single-cycle return to the stable level restarts the count from zero.
- Channels are fully independent. Simultaneous changes on several keys are accepted in the same cycle, each with its own pulse.
- Reset asserted mid-PENDING abandons the count. After release, key_clean = 0 even if the key is physically held; a held key is then re-accepted after DEBOUNCE_CYCLES+2 cycles with a key_press pulse.
- Outputs are glitch-free registered signals, safe for direct use by the PIO.

Decomposition:
- Shared package hps_system_key_pkg holds:
  - DEBOUNCE_CYCLES_DEFAULT = 500000.
  - DEBOUNCE_CYCLES_SIM = 8.
  - a localparam function for counter width.
  - state encoding constants ST_STABLE = 1'b0, ST_PENDING = 1'b1.
- One natural sub-module: hps_system_key_debounce_chan, a single-key synchronizer + FSM + counter with 1-bit ports. The top instantiates N_KEYS copies in a generate loop.

Test Plan (DEBOUNCE_CYCLES=8, ACTIVE_LOW=1, N_KEYS=2):
- Reset, key_raw=2'b11 held → key_clean=00, key_press=00, key_release=00 for 50 cycles.
- key_raw[0] 1→0 at edge 0, held → key_clean[0]=1 and key_press[0]=1 at edge 10; key_press[0]=0 at edge 11; key_clean[1]=0 throughout.
- key_raw[0] bounce pattern 0,1,0,0,1 (1 cycle each) then held 1 from an idle-pressed-free state → key_clean stays 0, no pulses.
- Key 0 pressed and stable, then key_raw[0]→1 held → key_clean[0]=0 with key_release[0]=1 exactly 10 cycles later, pulse width 1.
- Both keys 11→00 on the same edge → key_clean=11 and key_press=11 on the same cycle, 10 cycles later.
- Key 1 in PENDING (cnt=5), pulse reset_n low for 3 cycles with key still held → all outputs 0 immediately; key_clean[1]=1 with key_press[1]=1 at 10 cycles after reset release.

Source files
------------

// File: rtl/hps_system_key_pkg.sv
// Shared constants, state encoding and helpers for the HPS key debounce block.
package hps_system_key_pkg;

  localparam int unsigned DEBOUNCE_CYCLES_DEFAULT = 500000;
  localparam int unsigned DEBOUNCE_CYCLES_SIM     = 8;

  typedef enum logic {
    ST_STABLE  = 1'b0,
    ST_PENDING = 1'b1
  } key_state_e;

  // Counter must hold values up to DEBOUNCE_CYCLES-1 without wrapping.
  function automatic int unsigned cnt_width(input int unsigned cycles);
    return $clog2(cycles + 1);
  endfunction

endpackage

// File: rtl/hps_system_key_debounce_chan.sv
// Single key channel: 2-flop synchronizer, debounce FSM and registered press/release pulses.
module hps_system_key_debounce_chan
  import hps_system_key_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter int unsigned ACTIVE_LOW      = 1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic key_raw,
  output logic key_clean,
  output logic key_press,
  output logic key_release
);

  localparam int unsigned CW        = cnt_width(DEBOUNCE_CYCLES);
  localparam logic        IDLE_LVL  = (ACTIVE_LOW != 0);
  localparam logic        IMMEDIATE = (DEBOUNCE_CYCLES == 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic          sync1_q, sync2_q;
  key_state_e    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          clean_q, clean_d;
  logic          press_q, press_d;
  logic          release_q, release_d;
  logic          lvl;

  assign lvl = sync2_q ^ IDLE_LVL;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    clean_d   = clean_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    unique case (state_q)
      ST_STABLE: begin
        cnt_d = '0;
        if (lvl != clean_q) begin
          if (IMMEDIATE) begin
            clean_d   = lvl;
            press_d   = lvl;
            release_d = ~lvl;
          end else begin
            state_d = ST_PENDING;
            cnt_d   = CNT_ONE;
          end
        end
      end
      ST_PENDING: begin
        // Any return to the accepted level discards the partial count.
        if (lvl == clean_q) begin
          state_d = ST_STABLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          clean_d   = lvl;
          press_d   = lvl;
          release_d = ~lvl;
          state_d   = ST_STABLE;
          cnt_d     = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = ST_STABLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q   <= IDLE_LVL;
      sync2_q   <= IDLE_LVL;
      state_q   <= ST_STABLE;
      cnt_q     <= '0;
      clean_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      sync1_q   <= key_raw;
      sync2_q   <= sync1_q;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      clean_q   <= clean_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

  assign key_clean   = clean_q;
  assign key_press   = press_q;
  assign key_release = release_q;

endmodule

// File: rtl/hps_system_key_debounce.sv
// HPS key conditioning: N_KEYS independent debounce channels feeding the key PIO in_port.
module hps_system_key_debounce
  import hps_system_key_pkg::*;
#(
  parameter int unsigned N_KEYS          = 2,
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter int unsigned ACTIVE_LOW      = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [N_KEYS-1:0] key_raw,
  output logic [N_KEYS-1:0] key_clean,
  output logic [N_KEYS-1:0] key_press,
  output logic [N_KEYS-1:0] key_release
);

  for (genvar i = 0; i < N_KEYS; i++) begin : g_chan
    hps_system_key_debounce_chan #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .ACTIVE_LOW     (ACTIVE_LOW)
    ) u_chan (
      .clk        (clk),
      .reset_n    (reset_n),
      .key_raw    (key_raw[i]),
      .key_clean  (key_clean[i]),
      .key_press  (key_press[i]),
      .key_release(key_release[i])
    );
  end

endmodule

// File: tb/tb_hps_system_key_debounce.sv
// Directed plus randomized bench for hps_system_key_debounce against a sliding-window reference model.
module tb_hps_system_key_debounce;
  import hps_system_key_pkg::*;

  localparam int unsigned N = 2;
  localparam int unsigned D = DEBOUNCE_CYCLES_SIM;

  logic         clk = 1'b0;
  logic         reset_n;
  logic [N-1:0] key_raw;
  logic [N-1:0] key_clean, key_press, key_release;

  int total = 0;
  int bad   = 0;

  // Reference model state: raw samples per edge, level seen by the debouncer per edge.
  logic [N-1:0] samp[$];
  logic [N-1:0] seen[$];
  logic [N-1:0] exp_clean, exp_press, exp_release;

  hps_system_key_debounce #(
    .N_KEYS         (N),
    .DEBOUNCE_CYCLES(D),
    .ACTIVE_LOW     (1)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .key_raw    (key_raw),
    .key_clean  (key_clean),
    .key_press  (key_press),
    .key_release(key_release)
  );

  always #10 clk = ~clk;

  task automatic model_reset();
    samp.delete();
    seen.delete();
    samp.push_back('0);
    samp.push_back('0);
    for (int i = 0; i < int'(D); i++) seen.push_back('0);
    exp_clean   = '0;
    exp_press   = '0;
    exp_release = '0;
  endtask

  // A new level is accepted once the last D levels seen all differ from the accepted level.
  task automatic model_edge();
    logic [N-1:0] lvl;
    bit           all_diff;
    exp_press   = '0;
    exp_release = '0;
    if (!reset_n) begin
      model_reset();
      return;
    end
    samp.push_back(~key_raw);
    lvl = samp[samp.size() - 3];
    seen.push_back(lvl);
    while (samp.size() > 8) void'(samp.pop_front());
    while (seen.size() > 64) void'(seen.pop_front());
    for (int c = 0; c < int'(N); c++) begin
      all_diff = 1'b1;
      for (int k = 1; k <= int'(D); k++)
        if (seen[seen.size() - k][c] == exp_clean[c]) all_diff = 1'b0;
      if (all_diff) begin
        exp_clean[c]   = ~exp_clean[c];
        exp_press[c]   = exp_clean[c];
        exp_release[c] = ~exp_clean[c];
      end
    end
  endtask

  task automatic check(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check("clean", key_clean, exp_clean);
    check("press", key_press, exp_press);
    check("release", key_release, exp_release);
    check("pulse_excl", key_press & key_release, '0);
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    int hold[N];

    reset_n = 1'b0;
    key_raw = 2'b11;
    model_reset();
    #1;
    check("rst_clean", key_clean, 2'b00);
    check("rst_press", key_press, 2'b00);
    check("rst_release", key_release, 2'b00);
    steps(3);
    reset_n = 1'b1;
    steps(50);
    check("idle_clean", key_clean, 2'b00);

    // Key 0 press: accepted at edge D+2 after the change.
    key_raw = 2'b10;
    steps(D + 1);
    check("k0_press_early", {1'b0, key_press[0]}, 2'b00);
    step();
    check("k0_clean_at10", key_clean, 2'b01);
    check("k0_press_at10", key_press, 2'b01);
    step();
    check("k0_press_at11", key_press, 2'b00);

    // Key 0 release after stable press.
    steps(5);
    key_raw = 2'b11;
    steps(D + 2);
    check("k0_release_at10", key_release, 2'b01);
    check("k0_clean_rel", key_clean, 2'b00);
    step();
    check("k0_release_at11", key_release, 2'b00);

    // Bounce shorter than the debounce window is rejected.
    steps(4);
    foreach (samp[i]) ;
    key_raw = 2'b10; step();
    key_raw = 2'b11; step();
    key_raw = 2'b10; step();
    step();
    key_raw = 2'b11;
    steps(15);
    check("bounce_clean", key_clean, 2'b00);

    // Both keys change together and are accepted together.
    key_raw = 2'b00;
    steps(D + 2);
    check("both_clean", key_clean, 2'b11);
    check("both_press", key_press, 2'b11);
    key_raw = 2'b11;
    steps(D + 4);

    // Reset mid-pending on key 1 with the key still held.
    key_raw = 2'b01;
    steps(7);
    reset_n = 1'b0;
    #1;
    model_reset();
    check("midrst_clean", key_clean, 2'b00);
    check("midrst_press", key_press, 2'b00);
    steps(3);
    reset_n = 1'b1;
    steps(D + 1);
    check("rearm_early", key_clean, 2'b00);
    step();
    check("rearm_clean", key_clean, 2'b10);
    check("rearm_press", key_press, 2'b10);
    key_raw = 2'b11;
    steps(D + 4);

    // Randomized bouncing with hold times straddling the debounce window.
    for (int c = 0; c < int'(N); c++) hold[c] = int'($urandom_range(1, 2 * D));
    for (int t = 0; t < 800; t++) begin
      for (int c = 0; c < int'(N); c++) begin
        hold[c]--;
        if (hold[c] <= 0) begin
          key_raw[c] = ~key_raw[c];
          hold[c]    = ($urandom_range(0, 3) == 0) ? int'($urandom_range(D + 1, 3 * D))
                                                    : int'($urandom_range(1, D + 1));
        end
      end
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
